// File: rtl/port_out_arb_pkg.sv
// Shared types and the round-robin pick function for the output-port arbiter.
// Also used by the rr_arbiter picker, which other arbiters reuse.
package port_out_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam int unsigned OWNER_W = 3;
    localparam int unsigned MAX_REQ = 8;

    // Searches upward from ptr+1, wrapping at nreq. If no bit is set, ptr is returned.
    function automatic logic [OWNER_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [OWNER_W-1:0] ptr,
        input int unsigned        nreq
    );
        logic [OWNER_W-1:0] pick_v;
        logic [OWNER_W-1:0] idx_v;
        logic               found_v;
        pick_v  = ptr;
        found_v = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx_v = OWNER_W'((32'(ptr) + k) % nreq);
            if (!found_v && (k <= nreq) && req[idx_v]) begin
                pick_v  = idx_v;
                found_v = 1'b1;
            end
        end
        return pick_v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the next requester after ptr
// as a one-hot vector and as an index.
module rr_arbiter
    import port_out_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NREQ-1:0]    gnt,
    output logic [OWNER_W-1:0] idx
);

    logic [MAX_REQ-1:0] req_pad_s;

    assign req_pad_s = MAX_REQ'(req);

    // Pick the winner; the one-hot result stays zero when nobody requests.
    always_comb begin
        idx = rr_pick(req_pad_s, ptr, NREQ);
        if (|req) begin
            gnt = NREQ'(1'b1) << idx;
        end else begin
            gnt = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/port_out_arbiter.sv
// Round-robin arbiter sharing the 8-bit output port PO between NREQ requesters,
// with a post-write hold window. Optional owner lock: define PORT_OUT_ARB_LOCK_EN.
module port_out_arbiter
    import port_out_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic                CLK,
    input  logic                RESET,
`ifdef PORT_OUT_ARB_LOCK_EN
    input  logic                LOCK,
`endif
    input  logic [NREQ-1:0]     REQ,
    input  logic [8*NREQ-1:0]   WDATA,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     ACK,
    output logic [7:0]          PO,
    output logic [OWNER_W-1:0]  OWNER,
    output logic                BUSY
);

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [NREQ-1:0]    sel_oh_r;
    logic [OWNER_W-1:0] sel_idx_r;
    logic [OWNER_W-1:0] rr_ptr_r;
    logic [3:0]         cnt_r;
    logic [7:0]         po_r;
    logic [OWNER_W-1:0] owner_r;
    logic [NREQ-1:0]    req_eff_s;
    logic [NREQ-1:0]    pick_oh_s;
    logic [OWNER_W-1:0] pick_idx_s;
    logic               req_sel_s;
    logic               commit_s;
    logic [7:0]         wdata_sel_s;

`ifdef PORT_OUT_ARB_LOCK_EN
    logic               lock_r;
    logic [NREQ-1:0]    owner_oh_s;

    assign owner_oh_s = NREQ'(1'b1) << owner_r;

    // While locked, only the locked owner (the last committed writer) is eligible.
    always_comb begin
        if (lock_r) begin
            req_eff_s = REQ & owner_oh_s;
        end else begin
            req_eff_s = REQ;
        end
    end

    // Lock flag follows LOCK on every committed write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_r <= 1'b0;
        end else if (commit_s) begin
            lock_r <= LOCK;
        end
    end
`else
    assign req_eff_s = REQ;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req (req_eff_s),
        .ptr (rr_ptr_r),
        .gnt (pick_oh_s),
        .idx (pick_idx_s)
    );

    // Selected requester's level and data, muxed by the registered one-hot.
    always_comb begin
        req_sel_s   = |(REQ & sel_oh_r);
        wdata_sel_s = 8'h00;
        for (int i = 0; i < int'(NREQ); i++) begin
            wdata_sel_s = wdata_sel_s | (WDATA[8*i +: 8] & {8{sel_oh_r[i]}});
        end
    end

    assign commit_s = (state_r == GRANT) && req_sel_s;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; HOLD leaves in the cycle the count reads 1.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req_eff_s) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (req_sel_s && (HOLD_CYCLES != 32'd0)) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the state register and the latched selection.
    always_comb begin
        GNT  = {NREQ{1'b0}};
        ACK  = {NREQ{1'b0}};
        BUSY = 1'b0;
        case (state_r)
            IDLE: begin
                GNT  = {NREQ{1'b0}};
                ACK  = {NREQ{1'b0}};
                BUSY = 1'b0;
            end
            GRANT: begin
                GNT  = sel_oh_r;
                ACK  = sel_oh_r & REQ;
                BUSY = 1'b1;
            end
            HOLD: begin
                BUSY = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    // Datapath: latch the selection in IDLE, commit or abort in GRANT, count down in HOLD.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_oh_r  <= {NREQ{1'b0}};
            sel_idx_r <= {OWNER_W{1'b0}};
            rr_ptr_r  <= OWNER_W'(NREQ - 1);
            cnt_r     <= 4'd0;
            po_r      <= RESET_VAL;
            owner_r   <= {OWNER_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req_eff_s) begin
                        sel_oh_r  <= pick_oh_s;
                        sel_idx_r <= pick_idx_s;
                    end
                end
                GRANT: begin
                    // A withdrawn requester still consumes its turn.
                    rr_ptr_r <= sel_idx_r;
                    if (req_sel_s) begin
                        po_r    <= wdata_sel_s;
                        owner_r <= sel_idx_r;
                        cnt_r   <= 4'(HOLD_CYCLES);
                    end
                end
                HOLD: begin
                    cnt_r <= cnt_r - 4'd1;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign PO    = po_r;
    assign OWNER = owner_r;

endmodule

// File: doc/port_out_arbiter.md
Name: port_out_arbiter

Overview:
- Shares the CPU's single 8-bit parallel output port register (PO) between NREQ requesters, e.g. CPU core, debug loader and a test pattern source.
- Round-robin arbitration with a req/gnt/ack handshake and a configurable post-write hold window, so that observers sampling PO/IN see each value for a guaranteed number of cycles.
- Sits between the requesters and the output pins at the CPU8bit top level.
- The loopback IN = PO is unchanged and stays outside this block.

Parameters:
- NREQ, 2: number of requesters; legal range 2..8.
- HOLD_CYCLES, 2: idle cycles after each committed write before the next grant; legal range 0..15.
- RESET_VAL, 8'h00: value of PO after reset.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  NREQ  per-requester write request; level, held until ACK.
- WDATA  input  8*NREQ  packed write data; requester i uses bits [8*i+7:8*i].
- GNT  output  NREQ  one-hot grant; high only in the GRANT state.
- ACK  output  NREQ  one-hot; high in the cycle PO is loaded for that requester.
- PO  output  8  registered output port value.
- OWNER  output  3  index of the last committed writer.
- BUSY  output  1  high in the GRANT or HOLD state.

Behaviour:
- Reset (async assert, release sampled on CLK):
  - state = IDLE, PO = RESET_VAL, GNT = 0, ACK = 0, OWNER = 0, BUSY = 0.
  - rr_ptr = NREQ-1, so requester 0 wins first.
  - Hold counter = 0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE:
  - If REQ != 0, select the first set bit searching upward from rr_ptr+1, modulo NREQ.
  - Register the selection as sel and go to GRANT.
  - If REQ == 0, stay in IDLE.
- GRANT (one cycle): GNT[sel] = 1.
  - If REQ[sel] = 1:
    - ACK[sel] = 1 in the same cycle.
    - At the closing edge: PO <= WDATA[sel], OWNER <= sel, rr_ptr <= sel.
    - Go to HOLD with count = HOLD_CYCLES, or to IDLE if HOLD_CYCLES = 0.
  - If REQ[sel] = 0 (requester withdrew): abort.
    - No ACK; PO and OWNER unchanged.
    - rr_ptr <= sel, so the withdrawn requester loses its turn.
    - Go to IDLE.
- HOLD: count decrements each cycle; go to IDLE when count reaches 1 (exit in the cycle count = 1). REQ is ignored.
- Latency:
  - REQ rises in cycle t with the FSM idle → GNT/ACK in t+1 → new PO visible in t+2.
  - Back-to-back writes are spaced 2+HOLD_CYCLES cycles apart.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ grants.
- Simultaneous events:
  - Selection uses REQ as sampled in IDLE only.
  - A REQ that rises during GRANT or HOLD is serviced at the next IDLE.
- Requester protocol: drop REQ, or present new data, the cycle after ACK. Keeping REQ high means a new request.
- Reset mid-operation: immediate return to the reset values above. An in-flight GRANT is lost and PO is not written.
- WDATA of non-granted requesters is never observed.

Optional Feature:
- Macro: PORT_OUT_ARB_LOCK_EN.
- With the macro defined:
  - Adds input LOCK (1 bit).
  - If LOCK = 1 in a GRANT cycle that commits, that requester becomes the locked owner.
  - Subsequent IDLE selections grant only the locked owner, waiting if its REQ = 0, until a committed grant with LOCK = 0.
  - Reset clears the lock.
- Without the macro: no LOCK port; pure round-robin.

Decomposition:
- Package port_out_arb_pkg:
  - state enum (IDLE, GRANT, HOLD).
  - OWNER_W = 3.
  - Function rr_pick(req, ptr) returning the next index.
- Sub-module rr_arbiter:
  - Combinational round-robin picker, parameterised by NREQ.
  - Inputs req and ptr; outputs the one-hot result and the index.
  - Reused later by the bus arbiter.

Test Plan:
- Reset with RESET_VAL = 8'h5A, RESET pulsed asynchronously mid-cycle → PO = 8'h5A immediately; GNT = 0, BUSY = 0, OWNER = 0.
- REQ = 2'b10, WDATA1 = 8'hC3 from IDLE in cycle t → GNT = 2'b10 and ACK = 2'b10 in t+1; PO = 8'hC3 in t+2; OWNER = 1; BUSY high for t+1..t+3 (HOLD_CYCLES = 2).
- REQ = 2'b11 held, requesters incrementing data after each ACK → ACK alternates 0,1,0,1; commits exactly 4 cycles apart.
- Abort: REQ0 rises, then drops in its GRANT cycle while REQ1 is high → no ACK0; PO unchanged; next grant goes to 1.
- HOLD_CYCLES = 0, REQ = 2'b01 held → ACK0 every 2nd cycle.
- PORT_OUT_ARB_LOCK_EN defined: requester 0 commits with LOCK = 1 while REQ1 = 1 → requester 0 is granted repeatedly and requester 1 is starved. After a requester 0 commit with LOCK = 0 → the next grant goes to 1.
